// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-requester ALU arbiter.
// slave = arbiter view, master = environment view (requesters plus the ALU).
interface alu_arbiter_if #(
    parameter int DW  = 32,
    parameter int OPW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_aluop;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_aluop;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;

    logic           resp0_valid;
    logic           resp0_ready;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [DW-1:0]  resp_out;
    logic           resp_zero;
    logic           resp_negative;
    logic           resp_overflow;

    logic [OPW-1:0] alu_aluop;
    logic [DW-1:0]  alu_port_a;
    logic [DW-1:0]  alu_port_b;
    logic [DW-1:0]  alu_port_out;
    logic           alu_zero;
    logic           alu_negative;
    logic           alu_overflow;

    modport slave (
        input  req0_valid, req0_aluop, req0_a, req0_b,
        input  req1_valid, req1_aluop, req1_a, req1_b,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid,
        input  resp0_ready, resp1_ready,
        output resp_out, resp_zero, resp_negative, resp_overflow,
        output alu_aluop, alu_port_a, alu_port_b,
        input  alu_port_out, alu_zero, alu_negative, alu_overflow
    );

    modport master (
        output req0_valid, req0_aluop, req0_a, req0_b,
        output req1_valid, req1_aluop, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid,
        output resp0_ready, resp1_ready,
        input  resp_out, resp_zero, resp_negative, resp_overflow,
        input  alu_aluop, alu_port_a, alu_port_b,
        output alu_port_out, alu_zero, alu_negative, alu_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Define ALU_ARB_PERF_EN to add saturating grant/wait performance counters.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester per transfer
// EXEC  | op_reg drives the ALU for one cycle; result captured at its end
// RESP  | result held for the owner until its response handshake
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    alu_arbiter_if.slave  bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1,
    output logic [15:0]   wait_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           last_grant;
    logic           owner;
    logic           winner;
    logic           xfer;
    logic           ready0, ready1;
    logic           rvalid0, rvalid1;

    logic [OPW-1:0] op_aluop;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;

    logic [DW-1:0]  res_out;
    logic           res_zero;
    logic           res_negative;
    logic           res_overflow;

    // A lone requester always wins; on contention the one not granted last time wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid)
            winner = ~last_grant;
        else
            winner = bus.req1_valid;
    end

    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                ready0 = bus.req0_valid && !winner;
                ready1 = bus.req1_valid && winner;
                xfer   = bus.req0_valid || bus.req1_valid;
                if (xfer)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rvalid0 = !owner;
                rvalid1 = owner;
                if (owner ? bus.resp1_ready : bus.resp0_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_aluop   <= '0;
            op_a       <= '0;
            op_b       <= '0;
        end else if (xfer) begin
            last_grant <= winner;
            owner      <= winner;
            op_aluop   <= winner ? bus.req1_aluop : bus.req0_aluop;
            op_a       <= winner ? bus.req1_a     : bus.req0_a;
            op_b       <= winner ? bus.req1_b     : bus.req0_b;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_out      <= '0;
            res_zero     <= 1'b0;
            res_negative <= 1'b0;
            res_overflow <= 1'b0;
        end else if (state == EXEC) begin
            res_out      <= bus.alu_port_out;
            res_zero     <= bus.alu_zero;
            res_negative <= bus.alu_negative;
            res_overflow <= bus.alu_overflow;
        end
    end

    assign bus.req0_ready    = ready0;
    assign bus.req1_ready    = ready1;
    assign bus.resp0_valid   = rvalid0;
    assign bus.resp1_valid   = rvalid1;
    assign bus.resp_out      = res_out;
    assign bus.resp_zero     = res_zero;
    assign bus.resp_negative = res_negative;
    assign bus.resp_overflow = res_overflow;
    // ALU inputs keep the last issued op outside EXEC rather than being cleared.
    assign bus.alu_aluop     = op_aluop;
    assign bus.alu_port_a    = op_a;
    assign bus.alu_port_b    = op_b;

`ifdef ALU_ARB_PERF_EN
    logic stalled;
    assign stalled = (bus.req0_valid && !ready0) || (bus.req1_valid && !ready1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            wait_cnt   <= '0;
        end else begin
            if (ready0 && grant_cnt0 != 16'hFFFF)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (ready1 && grant_cnt1 != 16'hFFFF)
                grant_cnt1 <= grant_cnt1 + 16'd1;
            if (stalled && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    alu_arbiter_if #(.DW(32), .OPW(4)) bus ();

`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant_cnt0, grant_cnt1, wait_cnt;
`endif

    alu_arbiter #(.DW(32), .OPW(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
`ifdef ALU_ARB_PERF_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
        .wait_cnt(wait_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU: returns {overflow, negative, zero, result}.
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {v, r[31], (r == 32'd0), r};
    endfunction

    always_comb begin
        {bus.alu_overflow, bus.alu_negative, bus.alu_zero, bus.alu_port_out} =
            alu_fn(bus.alu_aluop, bus.alu_port_a, bus.alu_port_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Contention goes to the requester not granted last; otherwise whoever asks.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    // Model: one op in flight at most; age counts cycles since acceptance.
    logic        m_pend, m_owner, m_last;
    int          m_age;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [34:0] m_res;
    logic [15:0] m_gc0, m_gc1, m_wc;
    logic        t_v0, t_v1, t_w, t_r0, t_r1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pend = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
            m_op = '0; m_a = '0; m_b = '0; m_res = '0;
            m_gc0 = '0; m_gc1 = '0; m_wc = '0;
        end else begin
            t_v0 = bus.req0_valid;
            t_v1 = bus.req1_valid;
            t_w  = pick(t_v0, t_v1, m_last);
            t_r0 = !m_pend && t_v0 && !t_w;
            t_r1 = !m_pend && t_v1 && t_w;
            if (((t_v0 && !t_r0) || (t_v1 && !t_r1)) && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            if (m_pend) begin
                if (m_age >= 2) begin
                    if (m_owner ? bus.resp1_ready : bus.resp0_ready) m_pend = 1'b0;
                end else begin
                    m_age++;
                    if (m_age == 2) m_res = alu_fn(m_op, m_a, m_b);
                end
            end else if (t_v0 || t_v1) begin
                m_pend = 1'b1; m_age = 1; m_owner = t_w; m_last = t_w;
                m_op = t_w ? bus.req1_aluop : bus.req0_aluop;
                m_a  = t_w ? bus.req1_a : bus.req0_a;
                m_b  = t_w ? bus.req1_b : bus.req0_b;
                if (!t_w && m_gc0 != 16'hFFFF) m_gc0 = m_gc0 + 16'd1;
                if (t_w && m_gc1 != 16'hFFFF) m_gc1 = m_gc1 + 16'd1;
            end
        end
    end

    always @(negedge CLK) begin
        logic w;
        if (!RST) begin
            w = pick(bus.req0_valid, bus.req1_valid, m_last);
            check("req0_ready", 32'(bus.req0_ready), 32'(!m_pend && bus.req0_valid && !w));
            check("req1_ready", 32'(bus.req1_ready), 32'(!m_pend && bus.req1_valid && w));
            check("resp0_valid", 32'(bus.resp0_valid), 32'(m_pend && m_age >= 2 && !m_owner));
            check("resp1_valid", 32'(bus.resp1_valid), 32'(m_pend && m_age >= 2 && m_owner));
            check("resp_out", bus.resp_out, m_res[31:0]);
            check("resp_flags", 32'({bus.resp_overflow, bus.resp_negative, bus.resp_zero}),
                  32'(m_res[34:32]));
            check("alu_aluop", 32'(bus.alu_aluop), 32'(m_op));
            check("alu_port_a", bus.alu_port_a, m_a);
            check("alu_port_b", bus.alu_port_b, m_b);
`ifdef ALU_ARB_PERF_EN
            check("grant_cnt0", 32'(grant_cnt0), 32'(m_gc0));
            check("grant_cnt1", 32'(grant_cnt1), 32'(m_gc1));
            check("wait_cnt", 32'(wait_cnt), 32'(m_wc));
`endif
        end
    end

    // sel: 0 req0_ready, 1 req1_ready, 2 resp0_valid, 3 resp1_valid
    task automatic wait_for(input int sel, input string name, output int cyc);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 50) begin
            @(negedge CLK);
            cyc++;
            case (sel)
                0: hit = bus.req0_ready;
                1: hit = bus.req1_ready;
                2: hit = bus.resp0_valid;
                default: hit = bus.resp1_valid;
            endcase
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: got no event after %0d cycles expected event", name, cyc);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_aluop = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_aluop = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Returns one step after the accept edge, i.e. during the EXEC cycle.
    task automatic issue(input int n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int c;
        @(posedge CLK); #1;
        set_req(n, 1'b1, op, a, b);
        wait_for(n, "accept", c);
        @(posedge CLK); #1;
        if (n == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [31:0] out, input logic [2:0] flags);
        check({name, "_out"}, bus.resp_out, out);
        check({name, "_flags"}, 32'({bus.resp_overflow, bus.resp_negative, bus.resp_zero}),
              32'(flags));
    endtask

    initial begin
        int c;
        logic [31:0] snap;
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Idle after reset
        repeat (5) @(negedge CLK);
        check("idle_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("idle_rvalid", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
        check("idle_out", bus.resp_out, 32'd0);
        check("idle_alu", {bus.alu_port_a | bus.alu_port_b}, 32'd0);

        // ADD 5+7 on requester 0
        issue(0, OP_ADD, 32'd5, 32'd7);
        wait_for(2, "add_resp", c);
        check("add_latency", 32'(c), 32'd2);
        expect_resp("add", 32'd12, 3'b000);
        check("add_resp1_valid", 32'(bus.resp1_valid), 32'd0);

        // Simultaneous requests after reset: req0 first
        do_reset();
        @(posedge CLK); #1;
        set_req(0, 1'b1, OP_SUB, 32'd9, 32'd9);
        set_req(1, 1'b1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
        @(negedge CLK);
        check("pair1_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        @(posedge CLK); #1;
        bus.req0_valid = 1'b0;
        wait_for(2, "sub_resp", c);
        expect_resp("sub", 32'd0, 3'b001);
        wait_for(1, "or_accept", c);
        check("or_accept_delay", 32'(c), 32'd1);
        @(posedge CLK); #1;
        bus.req1_valid = 1'b0;
        wait_for(3, "or_resp", c);
        expect_resp("or", 32'h0000_00FF, 3'b000);

        // Next pair: last grant was requester 1, so requester 0 wins
        @(posedge CLK); #1;
        set_req(0, 1'b1, OP_AND, 32'h0000_FF00, 32'h0000_0FF0);
        set_req(1, 1'b1, OP_XOR, 32'd3, 32'd5);
        @(negedge CLK);
        check("pair2_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        @(posedge CLK); #1;
        bus.req0_valid = 1'b0;
        wait_for(2, "and_resp", c);
        expect_resp("and", 32'h0000_0F00, 3'b000);
        wait_for(1, "xor_accept", c);
        @(posedge CLK); #1;
        bus.req1_valid = 1'b0;
        wait_for(3, "xor_resp", c);
        expect_resp("xor", 32'd6, 3'b000);

        // Signed overflow on requester 1
        issue(1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        wait_for(3, "ovf_resp", c);
        expect_resp("ovf", 32'h8000_0000, 3'b110);

        // Backpressure on response 0 while requester 1 waits
        @(posedge CLK); #1;
        bus.resp0_ready = 1'b0;
        issue(0, OP_SUB, 32'd3, 32'd5);
        set_req(1, 1'b1, OP_OR, 32'd1, 32'd2);
        wait_for(2, "bp_resp", c);
        snap = bus.resp_out;
        check("bp_out", snap, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("bp_hold_valid", 32'(bus.resp0_valid), 32'd1);
            check("bp_hold_out", bus.resp_out, snap);
            check("bp_req1_blocked", 32'(bus.req1_ready), 32'd0);
        end
        @(posedge CLK); #1;
        bus.resp0_ready = 1'b1;
        wait_for(1, "bp_req1_accept", c);
        check("bp_accept_delay", 32'(c), 32'd2);
        @(posedge CLK); #1;
        bus.req1_valid = 1'b0;
        wait_for(3, "bp_req1_resp", c);
        expect_resp("bp_or", 32'd3, 3'b000);

        // Reset during EXEC discards the op
        issue(0, OP_ADD, 32'd1, 32'd2);
        do_reset();
        repeat (4) begin
            @(negedge CLK);
            check("rst_no_resp", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
        end
`ifdef ALU_ARB_PERF_EN
        check("rst_grant_cnt", 32'({grant_cnt0, grant_cnt1}), 32'd0);
`endif
        issue(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        wait_for(3, "slt_resp", c);
        expect_resp("slt", 32'd1, 3'b000);
`ifdef ALU_ARB_PERF_EN
        check("slt_grant_cnt1", 32'(grant_cnt1), 32'd1);
`endif
        repeat (3) @(posedge CLK);
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
